// File: rtl/rapids_defs.sv
// rtl/rapids_defs.sv - shared control-FSM constants and fetch-stage state encoding
package rapids_defs;

    localparam logic [4:0] HALT       = 5'b00000;
    localparam logic [4:0] READ_INS   = 5'b01000;
    localparam logic [4:0] WAIT_LOAD  = 5'b01010;
    localparam logic [4:0] WAIT_STORE = 5'b01100;
    localparam logic [4:0] DO         = 5'b01001;
    localparam logic [4:0] TRAP       = 5'b10000;

    typedef enum logic [1:0] {
        IF_IDLE  = 2'b00,
        IF_REQ   = 2'b01,
        IF_DONE  = 2'b10,
        IF_FAULT = 2'b11
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - req/ack instruction memory port
interface instr_fetch_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_err;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata,
        input  mem_err
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata,
        output mem_err
    );
endinterface

// File: rtl/seg_check.sv
// rtl/seg_check.sv - word-aligned inclusive segment bounds check
module seg_check #(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] limit,
    output logic              legal
);
    // aligned word address inside [base, limit], unsigned compare
    always_comb begin
        legal = (addr[1:0] == 2'b00) && (addr >= base) && (addr <= limit);
    end
endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage feeding the control FSM
module instr_fetch
    import rapids_defs::*;
#(
    parameter int              ADDR_W    = 32,
    parameter int              DATA_W    = 32,
    parameter logic [ADDR_W-1:0] SEG_BASE  = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] SEG_LIMIT = 32'h0000_FFFC,
    parameter int              TIMEOUT   = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch,
    input  logic              flush,
    input  logic [ADDR_W-1:0] pc,
    instr_fetch_if.master     mem,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic              wait_instr,
    output logic              instr_segv
);
    localparam int              CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    fetch_state_t      state_q, state_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              valid_q, valid_d;
    logic              segv_q, segv_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pc_legal;
    logic              start;

    seg_check #(.ADDR_W(ADDR_W)) u_seg_check (
        .addr  (pc),
        .base  (SEG_BASE),
        .limit (SEG_LIMIT),
        .legal (pc_legal)
    );

    // state and output registers; async reset drops mem_req immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IF_IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
            segv_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            segv_q  <= segv_d;
            cnt_q   <= cnt_d;
        end
    end

    // next-state and next register values; flush overrides everything
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        valid_d = valid_q;
        segv_d  = segv_q;
        cnt_d   = cnt_q;
        start   = 1'b0;

        case (state_q)
            IF_IDLE: begin
                start = fetch;
            end
            IF_REQ: begin
                if (mem.mem_ack) begin
                    req_d = 1'b0;
                    if (mem.mem_err) begin
                        state_d = IF_FAULT;
                        segv_d  = 1'b1;
                    end else begin
                        state_d = IF_DONE;
                        instr_d = mem.mem_rdata;
                        valid_d = 1'b1;
                    end
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IF_FAULT;
                    segv_d  = 1'b1;
                    req_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            IF_DONE: begin
                if (!fetch) begin
                    state_d = IF_IDLE;
                    valid_d = 1'b0;
                end else if (pc != addr_q) begin
                    start = 1'b1;
                end
            end
            IF_FAULT: begin
                if (!fetch) begin
                    state_d = IF_IDLE;
                    segv_d  = 1'b0;
                end
            end
            default: state_d = IF_IDLE;
        endcase

        if (start) begin
            valid_d = 1'b0;
            if (pc_legal) begin
                state_d = IF_REQ;
                addr_d  = pc;
                req_d   = 1'b1;
                cnt_d   = '0;
                segv_d  = 1'b0;
            end else begin
                state_d = IF_FAULT;
                segv_d  = 1'b1;
            end
        end

        if (flush) begin
            state_d = IF_IDLE;
            req_d   = 1'b0;
            valid_d = 1'b0;
            segv_d  = 1'b0;
            instr_d = instr_q;
        end
    end

    assign mem.mem_req  = req_q;
    assign mem.mem_addr = addr_q;
    assign instr        = instr_q;
    assign instr_valid  = valid_q;
    assign instr_segv   = segv_q;
    assign wait_instr   = fetch & ~valid_q & ~segv_q;

endmodule
